// File: rtl/snow64_instr_decode_stage.sv
// Snow64 instruction-decode stage: splits 32-bit instructions into group fields,
// buffers up to two decoded entries and holds off issue after mul/div.
module snow64_instr_decode_stage #(
    parameter int unsigned WIDTH__ADDR     = 64,
    parameter int unsigned MUL_HOLD_CYCLES = 2,
    parameter int unsigned DIV_HOLD_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [WIDTH__ADDR-1:0] in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_group,
    output logic                   out_op_type,
    output logic [3:0]             out_ra_index,
    output logic [3:0]             out_rb_index,
    output logic [3:0]             out_rc_index,
    output logic [3:0]             out_oper,
    output logic [WIDTH__ADDR-1:0] out_signext_imm,
    output logic [WIDTH__ADDR-1:0] out_pc,
    output logic                   out_nop,
    output logic                   out_illegal,
    output logic                   hold_busy
);

    localparam int unsigned HOLD_MAX =
        (MUL_HOLD_CYCLES > DIV_HOLD_CYCLES) ? MUL_HOLD_CYCLES : DIV_HOLD_CYCLES;
    localparam int unsigned HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

    typedef struct packed {
        logic [2:0]             group;
        logic                   op_type;
        logic [3:0]             ra;
        logic [3:0]             rb;
        logic [3:0]             rc;
        logic [3:0]             oper;
        logic [WIDTH__ADDR-1:0] imm;
        logic [WIDTH__ADDR-1:0] pc;
        logic                   nop;
        logic                   illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } buf_state_t;

    function automatic dec_t decode(input logic [31:0] instr,
                                    input logic [WIDTH__ADDR-1:0] pc);
        dec_t d;
        logic bad;
        d       = '0;
        bad     = 1'b0;
        d.group = instr[31:29];
        d.ra    = instr[27:24];
        d.pc    = pc;
        case (instr[31:29])
            3'd0: begin
                d.op_type = instr[28];
                d.rb      = instr[23:20];
                d.rc      = instr[19:16];
                d.oper    = instr[15:12];
                d.imm     = {{(WIDTH__ADDR-12){instr[11]}}, instr[11:0]};
                bad       = (instr[15:12] >= 4'd13);
            end
            3'd1: begin
                d.oper = instr[23:20];
                d.imm  = {{(WIDTH__ADDR-20){instr[19]}}, instr[19:0]};
                bad    = (instr[23:20] >= 4'd12);
            end
            3'd2, 3'd3: begin
                d.rb   = instr[23:20];
                d.rc   = instr[19:16];
                d.oper = instr[15:12];
                d.imm  = {{(WIDTH__ADDR-12){instr[11]}}, instr[11:0]};
                bad    = (instr[15:12] >= 4'd9);
            end
            3'd4: begin
                d.op_type = instr[28];
                d.rb      = instr[23:20];
                d.oper    = instr[19:16];
                d.imm     = {{(WIDTH__ADDR-16){instr[15]}}, instr[15:0]};
                bad       = (instr[19:16] >= 4'd9);
            end
            default: begin
                // Unassigned groups use the three-register layout.
                d.rb   = instr[23:20];
                d.rc   = instr[19:16];
                d.oper = instr[15:12];
                bad    = 1'b1;
            end
        endcase
        if (bad) begin
            d.nop     = 1'b1;
            d.illegal = 1'b1;
            d.imm     = '0;
        end
        return d;
    endfunction

    buf_state_t        state;
    buf_state_t        state_nxt;
    dec_t              entry0;
    dec_t              entry1;
    dec_t              in_dec;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              retire;

    assign in_dec    = decode(in_instr, in_pc);
    assign out_valid = (state != ST_EMPTY) && (hold_cnt == '0);
    assign accept    = in_valid && in_ready && !flush;
    assign retire    = out_valid && out_ready && !flush;
    assign hold_busy = (hold_cnt != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !retire)      state_nxt = ST_TWO;
                else if (!accept && retire) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (retire) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            entry0   <= '0;
            entry1   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
            // entry0 is always the head; a retire shifts entry1 (or the newcomer) forward.
            if (retire) begin
                if (state == ST_TWO) entry0 <= entry1;
                else if (accept)     entry0 <= in_dec;
            end else if (accept) begin
                if (state == ST_EMPTY) entry0 <= in_dec;
                else                   entry1 <= in_dec;
            end
            if (retire && !entry0.nop && entry0.group == 3'd0 && entry0.oper == 4'd3)
                hold_cnt <= HOLD_W'(MUL_HOLD_CYCLES);
            else if (retire && !entry0.nop && entry0.group == 3'd0 && entry0.oper == 4'd4)
                hold_cnt <= HOLD_W'(DIV_HOLD_CYCLES);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign out_group       = entry0.group;
    assign out_op_type     = entry0.op_type;
    assign out_ra_index    = entry0.ra;
    assign out_rb_index    = entry0.rb;
    assign out_rc_index    = entry0.rc;
    assign out_oper        = entry0.oper;
    assign out_signext_imm = entry0.imm;
    assign out_pc          = entry0.pc;
    assign out_nop         = entry0.nop;
    assign out_illegal     = entry0.illegal;

endmodule

// File: tb/tb_snow64_instr_decode_stage.sv
// Scoreboard bench for snow64_instr_decode_stage: accepted instructions are
// modelled on entry and compared in order as they leave the stage.
module tb_snow64_instr_decode_stage;

    localparam int unsigned W = 64;

    typedef struct packed {
        logic [2:0]   group;
        logic         op_type;
        logic [3:0]   ra;
        logic [3:0]   rb;
        logic [3:0]   rc;
        logic [3:0]   oper;
        logic [W-1:0] imm;
        logic [W-1:0] pc;
        logic         nop;
        logic         illegal;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_instr = '0;
    logic [W-1:0] in_pc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   out_group;
    logic         out_op_type;
    logic [3:0]   out_ra_index;
    logic [3:0]   out_rb_index;
    logic [3:0]   out_rc_index;
    logic [3:0]   out_oper;
    logic [W-1:0] out_signext_imm;
    logic [W-1:0] out_pc;
    logic         out_nop;
    logic         out_illegal;
    logic         hold_busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    snow64_instr_decode_stage #(
        .WIDTH__ADDR(W),
        .MUL_HOLD_CYCLES(2),
        .DIV_HOLD_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_group(out_group),
        .out_op_type(out_op_type), .out_ra_index(out_ra_index),
        .out_rb_index(out_rb_index), .out_rc_index(out_rc_index), .out_oper(out_oper),
        .out_signext_imm(out_signext_imm), .out_pc(out_pc), .out_nop(out_nop),
        .out_illegal(out_illegal), .hold_busy(hold_busy)
    );

    // Reference decode written from the field tables, by group.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [W-1:0] pc);
        exp_t e;
        logic signed [W-1:0] s;
        int unsigned op;
        e = '0;
        e.group = ins[31:29];
        e.ra = ins[27:24];
        e.pc = pc;
        if (ins[31:29] == 3'd1) begin
            e.oper = ins[23:20];
            s = W'($signed(ins[19:0]));
            e.illegal = (ins[23:20] > 4'd11);
        end else if (ins[31:29] == 3'd4) begin
            e.op_type = ins[28];
            e.rb = ins[23:20];
            e.oper = ins[19:16];
            s = W'($signed(ins[15:0]));
            e.illegal = (ins[19:16] > 4'd8);
        end else begin
            e.op_type = (ins[31:29] == 3'd0) ? ins[28] : 1'b0;
            e.rb = ins[23:20];
            e.rc = ins[19:16];
            e.oper = ins[15:12];
            s = W'($signed(ins[11:0]));
            op = ins[15:12];
            if (ins[31:29] == 3'd0) e.illegal = (op > 12);
            else                    e.illegal = (op > 8) || (ins[31:29] > 3'd4);
        end
        e.nop = e.illegal;
        e.imm = e.illegal ? '0 : s;
        return e;
    endfunction

    // Advance one cycle; sample handshakes mid-cycle to feed and drain the scoreboard.
    task automatic tick();
        exp_t e;
        exp_t g;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                g = '{out_group, out_op_type, out_ra_index, out_rb_index, out_rc_index,
                      out_oper, out_signext_imm, out_pc, out_nop, out_illegal};
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got %h, required nothing", g);
                end else begin
                    e = sb.pop_front();
                    if (g !== e) begin
                        n_bad++;
                        $display("FAIL sb_entry: got %h, required %h", g, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_decode(in_instr, in_pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, hold_busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_ctrl: got v/r/h=%b, required 010", {out_valid, in_ready, hold_busy});
        end
        n_cmp++;
        if ({out_group, out_oper, out_ra_index, out_signext_imm, out_pc, out_nop} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got imm=%h pc=%h grp=%0d, required all 0",
                     out_signext_imm, out_pc, out_group);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins [4];
        logic [86:0] req [4];
        logic [86:0] got;
        ins[0] = 32'h1123_0FFF; req[0] = {1'b1, 3'd0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd0,  2'b00, 64'hFFFF_FFFF_FFFF_FFFF};
        ins[1] = 32'h2508_0000; req[1] = {1'b1, 3'd1, 1'b0, 4'd5, 4'd0, 4'd0, 4'd0,  2'b00, 64'hFFFF_FFFF_FFF8_0000};
        ins[2] = 32'hA000_0000; req[2] = {1'b1, 3'd5, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0,  2'b11, 64'h0};
        ins[3] = 32'h0000_D000; req[3] = {1'b1, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd13, 2'b11, 64'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = ins[i];
            in_pc = W'(32'h100 + 4 * i);
            tick();
            in_valid = 1'b0;
            got = {out_valid, out_group, out_op_type, out_ra_index, out_rb_index, out_rc_index,
                   out_oper, out_nop, out_illegal, out_signext_imm};
            n_cmp++;
            if (got !== req[i]) begin
                n_bad++;
                $display("FAIL decode_%0d: got %h, required %h", i, got, req[i]);
            end
            tick();
            n_cmp++;
            if (hold_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL decode_hold_%0d: got hold_busy=%b, required 0", i, hold_busy);
            end
        end
        // Random legal-group traffic with random backpressure.
        for (int i = 0; i < 60; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom;
            in_instr[31:29] = 3'($urandom_range(0, 4));
            in_pc = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: got %0d entries left, required 0", sb.size());
        end
    endtask

    task automatic test_hold();
        logic [31:0] ins [2];
        int req [2];
        int busy;
        ins[0] = 32'h0000_4000; req[0] = 8;
        ins[1] = 32'h0000_3000; req[1] = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = ins[i];
            in_pc = W'(32'h400);
            tick();
            in_instr = 32'h0123_0000;
            in_pc = W'(32'h404);
            tick();
            in_valid = 1'b0;
            busy = 0;
            for (int k = 0; k < 30 && !out_valid; k++) begin
                if (hold_busy && !out_valid) busy++;
                tick();
            end
            n_cmp++;
            if (busy != req[i] || out_valid !== 1'b1 || out_pc !== W'(32'h404)) begin
                n_bad++;
                $display("FAIL hold_%0d: got busy=%0d valid=%b pc=%h, required busy=%0d valid=1 pc=404",
                         i, busy, out_valid, out_pc, req[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h4123_0005; in_pc = W'(32'h200);
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_one_ready: got %b, required 1", in_ready);
        end
        in_instr = 32'h6456_1FFF; in_pc = W'(32'h204);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_full: got in_ready=%b, required 0", in_ready);
        end
        in_instr = 32'h9781_2345; in_pc = W'(32'h208);
        tick();
        tick();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01 || out_pc !== W'(32'h200)) begin
            n_bad++;
            $display("FAIL b2b_stall: got r/v=%b pc=%h, required 01 pc=200", {in_ready, out_valid}, out_pc);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_pc !== W'(32'h204)) begin
            n_bad++;
            $display("FAIL b2b_retire: got r=%b pc=%h, required 1 pc=204", in_ready, out_pc);
        end
        tick();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b11 || out_pc !== W'(32'h208)) begin
            n_bad++;
            $display("FAIL b2b_one_hold: got r/v=%b pc=%h, required 11 pc=208", {in_ready, out_valid}, out_pc);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: got valid=%b left=%0d, required 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0000_4000; in_pc = W'(32'h300);
        tick();
        in_instr = 32'h4123_0005; in_pc = W'(32'h304);
        tick();
        in_instr = 32'h6456_1FFF; in_pc = W'(32'h308);
        tick();
        n_cmp++;
        if ({hold_busy, in_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL flush_setup: got h/r=%b, required 10", {hold_busy, in_ready});
        end
        flush = 1'b1;
        in_instr = 32'h0123_0000; in_pc = W'(32'h30C);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, hold_busy} !== 3'b010 || out_pc !== '0 || out_signext_imm !== '0) begin
            n_bad++;
            $display("FAIL flush_state: got v/r/h=%b pc=%h imm=%h, required 010 0 0",
                     {out_valid, in_ready, hold_busy}, out_pc, out_signext_imm);
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL flush_no_accept: got %0d valid cycles, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hold();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
